stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/lap/clear sequencer for the stopwatch sub-second counter (14-bit, 0..9999 @ 10 kHz).
//  Converts start_stop/lap_reset buttons into count_enable and a counter-clear pulse.
//  Cascades the sub-second wrap into seconds/minutes registers.
//  Drives the frozen or live time to the 7-segment display formatter.
// PARAMETERS
//  SUBSEC_MAX  9999  last sub-second value before wrap; one carry per wrap
//  SEC_MAX     59    seconds wrap value
//  MIN_MAX     59    minutes wrap value; wrap sets overflow
// PORTS
//  clk_10000Hz    in   1   system clock, 10 kHz
//  reset          in   1   asynchronous, active-high; clears all state
//  btn_start_stop in   1   debounced level; rising edge = start/stop command
//  btn_lap_reset  in   1   debounced level; rising edge = lap/clear command
//  small_sec_in   in   14  sub-second count from counter output
//  count_enable   out  1   to counter count_enable
//  cnt_clear      out  1   1-cycle pulse to counter reset
//  disp_subsec    out  14  displayed sub-seconds
//  disp_sec       out  6   displayed seconds 0..SEC_MAX
//  disp_min       out  6   displayed minutes 0..MIN_MAX
//  lap_active     out  1   high while the display is frozen (LAP)
//  overflow       out  1   sticky; set when minutes wrap MIN_MAX->0
// BEHAVIOUR
//  Reset values: state IDLE, count_enable 0, cnt_clear 0, all disp_* 0, sec/min 0, lap_active 0, overflow 0, edge regs 0.
//  Command = rising edge (input 1, previous sample 0). A held button issues one command.
//  FSM, evaluated at each clk edge on the command sampled that edge:
//   IDLE : start_stop -> RUN; lap_reset -> IDLE + cnt_clear pulse (clear in place)
//   RUN  : start_stop -> PAUSE; lap_reset -> LAP (capture live time into disp_*)
//   LAP  : start_stop -> PAUSE, display returns to live; lap_reset -> RUN, freeze released
//   PAUSE: start_stop -> RUN; lap_reset -> IDLE, cnt_clear pulse, sec/min/overflow <= 0
//  Both commands on the same edge: start_stop wins; lap_reset is dropped.
//  count_enable = registered (state==RUN || state==LAP). Counter increments from the 2nd edge after the command edge.
//  cnt_clear: high exactly one cycle, on the edge after the clear decision. count_enable is 0 in that cycle.
//  Carry: sec increments once when small_sec_in==SUBSEC_MAX and previous sample !=SUBSEC_MAX, gated by count_enable.
//   Pausing while small_sec_in holds SUBSEC_MAX yields no second carry on resume.
//  sec==SEC_MAX on carry -> sec<=0, min+1. min==MIN_MAX on that carry -> min<=0, overflow<=1 (sticky until clear/reset).
//  Display: live (disp_* = small_sec_in, sec, min, registered 1 cycle) except in LAP. In LAP it holds the value captured on the LAP entry edge.
//   Counting continues underneath LAP.
//  A carry coinciding with LAP entry: the capture takes pre-carry sec/min.
//  Async reset mid-run: all outputs to reset values immediately; the counter shares the reset.
// STRUCTURE
//  stopwatch_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3), SUBSEC_MAX/SEC_MAX/MIN_MAX defaults, widths.
//  Sub-module btn_edge_detect (one instance per button): 1-cycle pulse on rising edge, async reset.
//  Main body: FSM, sec/min cascade, lap capture, output registers.
// TESTING
//  1 Reset, start_stop edge, 10000 cycles with model counter -> count_enable high from cycle 2; disp_sec 0->1 exactly once.
//  2 RUN at sec=5, lap_reset -> lap_active=1, disp_sec frozen at 5 for 30000 cycles; second lap_reset -> live disp_sec=8.
//  3 PAUSE, lap_reset -> cnt_clear high 1 cycle; sec=min=0; state IDLE; count_enable 0 throughout.
//  4 Both buttons rise same edge in RUN -> PAUSE; no lap capture; lap_active stays 0.
//  5 Preload min=59, sec=59; carry -> sec=0, min=0, overflow=1; stays 1 until clear.
//  6 Pause while small_sec_in=9999, hold 50 cycles, resume -> sec increments once only.
//     Async reset asserted mid-RUN -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch run/pause/lap/clear sequencer:
// FSM encoding, field widths, default wrap limits and a state helper.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int SUBSEC_W = 14;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;

  localparam int SUBSEC_MAX_DEF = 9999;
  localparam int SEC_MAX_DEF    = 59;
  localparam int MIN_MAX_DEF    = 59;

  typedef struct packed {
    logic [SUBSEC_W-1:0] subsec;
    logic [SEC_W-1:0]    sec;
    logic [MIN_W-1:0]    min;
  } time_t;

  // The external counter advances in both RUN and LAP; LAP only freezes the display.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge.sv
// Rising-edge detector for a debounced button level: one pulse per press,
// combinational from the level and its previous registered sample.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= btn;
    end
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button commands drive a RUN/LAP/PAUSE/IDLE FSM, the
// sub-second wrap cascades into seconds/minutes, and the display is live or frozen.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int SUBSEC_MAX = SUBSEC_MAX_DEF,
  parameter int SEC_MAX    = SEC_MAX_DEF,
  parameter int MIN_MAX    = MIN_MAX_DEF
) (
  input  logic                clk_10000Hz,
  input  logic                reset,
  input  logic                btn_start_stop,
  input  logic                btn_lap_reset,
  input  logic [SUBSEC_W-1:0] small_sec_in,
  output logic                count_enable,
  output logic                cnt_clear,
  output logic [SUBSEC_W-1:0] disp_subsec,
  output logic [SEC_W-1:0]    disp_sec,
  output logic [MIN_W-1:0]    disp_min,
  output logic                lap_active,
  output logic                overflow,
  output state_t              fsm_state
);

  localparam logic [SUBSEC_W-1:0] SUB_LAST = SUBSEC_W'(SUBSEC_MAX);
  localparam logic [SEC_W-1:0]    SEC_LAST = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0]    MIN_LAST = MIN_W'(MIN_MAX);

  logic ss_cmd;
  logic lr_raw;
  logic lr_cmd;

  btn_edge_detect u_edge_ss (
    .clk  (clk_10000Hz),
    .rst  (reset),
    .btn  (btn_start_stop),
    .rise (ss_cmd)
  );

  btn_edge_detect u_edge_lr (
    .clk  (clk_10000Hz),
    .rst  (reset),
    .btn  (btn_lap_reset),
    .rise (lr_raw)
  );

  // Simultaneous presses: start/stop takes the edge, lap/reset is discarded.
  assign lr_cmd = lr_raw & ~ss_cmd;

  state_t state;
  state_t state_next;
  logic   clear_req;

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_cmd) begin
          state_next = ST_RUN;
        end else if (lr_cmd) begin
          clear_req = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_cmd) begin
          state_next = ST_PAUSE;
        end else if (lr_cmd) begin
          state_next = ST_LAP;
        end
      end
      ST_LAP: begin
        if (ss_cmd) begin
          state_next = ST_PAUSE;
        end else if (lr_cmd) begin
          state_next = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ss_cmd) begin
          state_next = ST_RUN;
        end else if (lr_cmd) begin
          state_next = ST_IDLE;
          clear_req  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fsm_state = state;

  // Carry fires once per arrival at SUBSEC_MAX; a value held across a pause
  // is not a new arrival because prev_subsec keeps tracking it.
  logic [SUBSEC_W-1:0] prev_subsec;
  logic                carry;
  logic [SEC_W-1:0]    sec;
  logic [MIN_W-1:0]    min;

  assign carry = count_enable && (small_sec_in == SUB_LAST) && (prev_subsec != SUB_LAST);

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      prev_subsec <= '0;
    end else begin
      prev_subsec <= small_sec_in;
    end
  end

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      sec      <= '0;
      min      <= '0;
      overflow <= 1'b0;
    end else if (clear_req) begin
      sec      <= '0;
      min      <= '0;
      overflow <= 1'b0;
    end else if (carry) begin
      if (sec == SEC_LAST) begin
        sec <= '0;
        if (min == MIN_LAST) begin
          min      <= '0;
          overflow <= 1'b1;
        end else begin
          min <= min + 1'b1;
        end
      end else begin
        sec <= sec + 1'b1;
      end
    end
  end

  // Entering LAP loads the pre-carry live time like any other cycle; only
  // staying in LAP holds it.
  logic  hold_disp;
  time_t live_time;

  assign hold_disp = (state == ST_LAP) && (state_next == ST_LAP);
  assign live_time = '{subsec: small_sec_in, sec: sec, min: min};

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      count_enable <= 1'b0;
      cnt_clear    <= 1'b0;
      lap_active   <= 1'b0;
      disp_subsec  <= '0;
      disp_sec     <= '0;
      disp_min     <= '0;
    end else begin
      count_enable <= is_counting(state);
      cnt_clear    <= clear_req;
      lap_active   <= (state_next == ST_LAP);
      if (!hold_disp) begin
        disp_subsec <= live_time.subsec;
        disp_sec    <= live_time.sec;
        disp_min    <= live_time.min;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: emulates the sub-second counter, runs a
// time-based reference model and compares every cycle plus literal checkpoints.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         btn_start_stop;
  logic         btn_lap_reset;
  logic [13:0]  ctr;
  logic         count_enable;
  logic         cnt_clear;
  logic [13:0]  disp_subsec;
  logic [5:0]   disp_sec;
  logic [5:0]   disp_min;
  logic         lap_active;
  logic         overflow;
  state_t       dbg_state;

  stopwatch_ctrl dut (
    .clk_10000Hz    (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .small_sec_in   (ctr),
    .count_enable   (count_enable),
    .cnt_clear      (cnt_clear),
    .disp_subsec    (disp_subsec),
    .disp_sec       (disp_sec),
    .disp_min       (disp_min),
    .lap_active     (lap_active),
    .overflow       (overflow),
    .fsm_state      (dbg_state)
  );

  // External sub-second counter; load lets the bench jump it close to a wrap.
  logic        load_en;
  logic [13:0] load_val;

  always @(posedge clk or posedge reset) begin
    if (reset) ctr <= '0;
    else if (load_en) ctr <= load_val;
    else if (cnt_clear) ctr <= '0;
    else if (count_enable) ctr <= (ctr == 14'd9999) ? 14'd0 : ctr + 14'd1;
  end

  // ---------------- reference model ----------------
  // Time is a single count of elapsed seconds; the mode is three flags.
  int m_elapsed, m_psub, m_dsub, m_dsec, m_dmin, sub;
  bit m_running, m_frozen, m_paused, m_ovf, m_lap, m_clr, m_en;
  bit m_pss, m_plr, ss, lr, carry, was_frozen, was_running, clear;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_elapsed = 0; m_psub = 0; m_dsub = 0; m_dsec = 0; m_dmin = 0;
      m_running = 0; m_frozen = 0; m_paused = 0; m_ovf = 0;
      m_lap = 0; m_clr = 0; m_en = 0; m_pss = 0; m_plr = 0;
    end else begin
      ss = btn_start_stop && !m_pss;
      lr = btn_lap_reset && !m_plr && !ss;
      m_pss = btn_start_stop;
      m_plr = btn_lap_reset;
      sub = int'(ctr);
      carry = m_en && (sub == 9999) && (m_psub != 9999);
      m_psub = sub;
      was_frozen = m_frozen;
      was_running = m_running;
      clear = 0;
      if (m_running && !m_frozen) begin
        if (ss) begin m_running = 0; m_paused = 1; end
        else if (lr) m_frozen = 1;
      end else if (m_running) begin
        if (ss) begin m_running = 0; m_frozen = 0; m_paused = 1; end
        else if (lr) m_frozen = 0;
      end else if (m_paused) begin
        if (ss) begin m_running = 1; m_paused = 0; end
        else if (lr) begin m_paused = 0; clear = 1; end
      end else begin
        if (ss) m_running = 1;
        else if (lr) clear = 1;
      end
      if (!(was_frozen && m_frozen)) begin
        m_dsub = sub;
        m_dsec = m_elapsed % 60;
        m_dmin = m_elapsed / 60;
      end
      m_lap = m_frozen;
      m_clr = clear;
      m_en  = was_running;
      if (carry) begin
        m_elapsed++;
        if (m_elapsed == 3600) begin m_elapsed = 0; m_ovf = 1; end
      end
      if (clear) begin m_elapsed = 0; m_ovf = 0; end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  bit started = 0;
  logic [29:0] exp_vec, act_vec;

  always @(negedge clk) begin
    if (started && !reset) begin
      exp_vec = {m_en, m_clr, 14'(m_dsub), 6'(m_dsec), 6'(m_dmin), m_lap, m_ovf};
      act_vec = {count_enable, cnt_clear, disp_subsec, disp_sec, disp_min, lap_active, overflow};
      n_vec++;
      if (act_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t got %h expected %h", $time, act_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic l);
    btn_start_stop = s;
    btn_lap_reset  = l;
    @(negedge clk);
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
  endtask

  // Each iteration jumps the counter to 9998 so it wraps two edges later.
  task automatic fast_carries(input int n);
    repeat (n) begin
      load_val = 14'd9998;
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
      tick(2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    load_en  = 1'b0;
    load_val = '0;
    tick(3);
    chk("rst_count_enable", count_enable, 0);
    chk("rst_disp_sec", disp_sec, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    started = 1;
    tick(2);

    // 1: start, real counting through the first second
    press(1, 0);
    chk("t1_ce_cycle1", count_enable, 0);
    tick(1);
    chk("t1_ce_cycle2", count_enable, 1);
    tick(10000);
    chk("t1_sec_before", disp_sec, 0);
    tick(1);
    chk("t1_sec_after", disp_sec, 1);

    // 2: lap freeze at 5 s while three more seconds elapse
    fast_carries(4);
    tick(1);
    chk("t2_sec_pre_lap", disp_sec, 5);
    press(0, 1);
    chk("t2_lap_active", lap_active, 1);
    chk("t2_frozen_start", disp_sec, 5);
    tick(30010);
    chk("t2_frozen_end", disp_sec, 5);
    press(0, 1);
    chk("t2_live_sec", disp_sec, 8);
    chk("t2_lap_released", lap_active, 0);

    // 4: both buttons together from RUN
    press(1, 1);
    chk("t4_lap_active", lap_active, 0);
    tick(1);
    chk("t4_ce_off", count_enable, 0);
    chk("t4_state", dbg_state, ST_PAUSE);

    // 3: clear from PAUSE
    press(0, 1);
    chk("t3_clear_pulse", cnt_clear, 1);
    chk("t3_ce_during_clear", count_enable, 0);
    tick(1);
    chk("t3_clear_done", cnt_clear, 0);
    chk("t3_sec_zero", disp_sec, 0);
    chk("t3_min_zero", disp_min, 0);
    chk("t3_state", dbg_state, ST_IDLE);

    // 6: pause while the sub-second input sits at 9999
    press(1, 0);
    tick(5);
    load_val = 14'd9999;
    load_en  = 1'b1;
    btn_start_stop = 1'b1;
    @(negedge clk);
    btn_start_stop = 1'b0;
    @(negedge clk);
    load_en = 1'b0;
    tick(50);
    chk("t6_sec_paused", disp_sec, 1);
    chk("t6_ce_paused", count_enable, 0);
    press(1, 0);
    tick(30);
    chk("t6_sec_resumed", disp_sec, 1);

    // 5: reach 59:59, then wrap into overflow
    fast_carries(3598);
    tick(1);
    chk("t5_sec_59", disp_sec, 59);
    chk("t5_min_59", disp_min, 59);
    chk("t5_ovf_pre", overflow, 0);
    fast_carries(1);
    tick(1);
    chk("t5_sec_wrap", disp_sec, 0);
    chk("t5_min_wrap", disp_min, 0);
    chk("t5_ovf_set", overflow, 1);
    chk("t5_model_ovf", m_ovf, 1);
    fast_carries(5);
    tick(1);
    chk("t5_ovf_sticky", overflow, 1);
    chk("t5_sec_after", disp_sec, 5);
    press(1, 0);
    tick(2);
    press(0, 1);
    tick(1);
    chk("t5_ovf_cleared", overflow, 0);

    // async reset in the middle of a run
    press(1, 0);
    tick(20);
    chk("ar_ce_before", count_enable, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_ce", count_enable, 0);
    chk("ar_clr", cnt_clear, 0);
    chk("ar_subsec", disp_subsec, 0);
    chk("ar_sec", disp_sec, 0);
    chk("ar_min", disp_min, 0);
    chk("ar_lap", lap_active, 0);
    chk("ar_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
